// File: rtl/gb80_pkg.sv
// Shared GB80 encodings: pair-command ops, pair selectors, register-file codes
// and the register-pair sequencer state type.
package gb80_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    localparam logic [1:0] PAIR_BC   = 2'b00;
    localparam logic [1:0] PAIR_DE   = 2'b01;
    localparam logic [1:0] PAIR_HL   = 2'b10;
    localparam logic [1:0] PAIR_RSVD = 2'b11;

    localparam int REG_CODE_W = 3;

    localparam logic [REG_CODE_W-1:0] REG_B   = 3'd0;
    localparam logic [REG_CODE_W-1:0] REG_C   = 3'd1;
    localparam logic [REG_CODE_W-1:0] REG_D   = 3'd2;
    localparam logic [REG_CODE_W-1:0] REG_E   = 3'd3;
    localparam logic [REG_CODE_W-1:0] REG_H   = 3'd4;
    localparam logic [REG_CODE_W-1:0] REG_L   = 3'd5;
    localparam logic [REG_CODE_W-1:0] REG_MEM = 3'd6;
    localparam logic [REG_CODE_W-1:0] REG_A   = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_H  = 3'd1,
        RD_L  = 3'd2,
        CAP_L = 3'd3,
        WR_H  = 3'd4,
        WR_L  = 3'd5,
        RESP  = 3'd6
    } seq_state_t;

endpackage

// File: rtl/reg_pair_decode.sv
// Register pair selector to hi/lo register-file codes. With REG_PAIR_SEQ_ACCUM_EN
// defined, pair 11 maps to the accumulator (lo = A) instead of being illegal.
module reg_pair_decode
    import gb80_pkg::*;
(
    input  logic [1:0]            pair,
    output logic [REG_CODE_W-1:0] hi_addr,
    output logic [REG_CODE_W-1:0] lo_addr,
    output logic                  illegal
);

    always_comb begin
        hi_addr = REG_B;
        lo_addr = REG_C;
        illegal = 1'b0;
        case (pair)
            PAIR_BC: begin
                hi_addr = REG_B;
                lo_addr = REG_C;
            end
            PAIR_DE: begin
                hi_addr = REG_D;
                lo_addr = REG_E;
            end
            PAIR_HL: begin
                hi_addr = REG_H;
                lo_addr = REG_L;
            end
            default: begin
`ifdef REG_PAIR_SEQ_ACCUM_EN
                hi_addr = REG_A;
                lo_addr = REG_A;
                illegal = 1'b0;
`else
                hi_addr = REG_B;
                lo_addr = REG_B;
                illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/reg_pair_sequencer.sv
// Sequences 16-bit register-pair commands into 8-bit register-file strobes and
// returns the pair value on a response channel. Optional: REG_PAIR_SEQ_ACCUM_EN.
module reg_pair_sequencer
    import gb80_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [1:0]              i_cmd_op,
    input  logic [1:0]              i_cmd_pair,
    input  logic [2*DATA_WIDTH-1:0] i_cmd_data,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [2*DATA_WIDTH-1:0] o_rsp_data,
    output logic                    o_rsp_err,
    output logic                    o_rf_wr_en,
    output logic                    o_rf_rd_en,
    output logic [ADDRESS_WIDTH-1:0] o_rf_addr,
    output logic [DATA_WIDTH-1:0]   o_rf_data,
    input  logic [DATA_WIDTH-1:0]   i_rf_data,
    output seq_state_t              o_state
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    // Handshakes: a command is taken on a rising edge with i_cmd_valid & o_cmd_ready;
    // a response is retired on a rising edge with o_rsp_valid & i_rsp_ready.

    seq_state_t state, state_next;

    logic [1:0]              op_q;
    logic [ADDRESS_WIDTH-1:0] hi_q, lo_q;
    logic                    accum_q;
    logic                    err_q;
    logic [PW-1:0]           data_q;

    logic [REG_CODE_W-1:0]   dec_hi, dec_lo;
    logic                    dec_illegal;
    logic                    accum_in;
    logic [PW-1:0]           read_val;
    logic [PW-1:0]           cap_val;

    reg_pair_decode u_decode (
        .pair    (i_cmd_pair),
        .hi_addr (dec_hi),
        .lo_addr (dec_lo),
        .illegal (dec_illegal)
    );

`ifdef REG_PAIR_SEQ_ACCUM_EN
    assign accum_in = (i_cmd_pair == PAIR_RSVD);
`else
    assign accum_in = 1'b0;
`endif

    // Value captured in CAP_L; accumulator accesses keep the hi byte at zero.
    always_comb begin
        read_val = {accum_q ? {DW{1'b0}} : data_q[PW-1:DW], i_rf_data};
        case (op_q)
            OP_INC:  cap_val = read_val + PW'(1);
            OP_DEC:  cap_val = read_val - PW'(1);
            default: cap_val = read_val;
        endcase
        if (accum_q) begin
            cap_val[PW-1:DW] = '0;
        end
    end

    always_comb begin
        state_next = state;
        o_rf_rd_en = 1'b0;
        o_rf_wr_en = 1'b0;
        o_rf_addr  = '0;
        o_rf_data  = '0;
        case (state)
            IDLE: begin
                if (i_cmd_valid) begin
                    if (dec_illegal) begin
                        state_next = RESP;
                    end else if (i_cmd_op == OP_WRITE) begin
                        state_next = accum_in ? WR_L : WR_H;
                    end else begin
                        state_next = accum_in ? RD_L : RD_H;
                    end
                end
            end
            RD_H: begin
                o_rf_rd_en = 1'b1;
                o_rf_addr  = hi_q;
                state_next = RD_L;
            end
            RD_L: begin
                o_rf_rd_en = 1'b1;
                o_rf_addr  = lo_q;
                state_next = CAP_L;
            end
            CAP_L: begin
                if (op_q == OP_READ) begin
                    state_next = RESP;
                end else begin
                    state_next = accum_q ? WR_L : WR_H;
                end
            end
            WR_H: begin
                o_rf_wr_en = 1'b1;
                o_rf_addr  = hi_q;
                o_rf_data  = data_q[PW-1:DW];
                state_next = WR_L;
            end
            WR_L: begin
                o_rf_wr_en = 1'b1;
                o_rf_addr  = lo_q;
                o_rf_data  = data_q[DW-1:0];
                state_next = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            op_q    <= OP_READ;
            hi_q    <= '0;
            lo_q    <= '0;
            accum_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        op_q    <= i_cmd_op;
                        hi_q    <= ADDRESS_WIDTH'(dec_hi);
                        lo_q    <= ADDRESS_WIDTH'(dec_lo);
                        accum_q <= accum_in;
                        err_q   <= dec_illegal;
                        if (!dec_illegal && i_cmd_op == OP_WRITE) begin
                            data_q <= accum_in ? {{DW{1'b0}}, i_cmd_data[DW-1:0]} : i_cmd_data;
                        end else begin
                            data_q <= '0;
                        end
                    end
                end
                RD_L: begin
                    if (!accum_q) begin
                        data_q[PW-1:DW] <= i_rf_data;
                    end
                end
                CAP_L: data_q <= cap_val;
                RESP: begin
                    if (i_rsp_ready) begin
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_data  = (state == RESP) ? data_q : '0;
    assign o_rsp_err   = (state == RESP) & err_q;
    assign o_state     = state;

endmodule

// File: tb/tb_reg_pair_sequencer.sv
// Directed bench for reg_pair_sequencer with a registered-read register-file model
// and an ordered write scoreboard.
module tb_reg_pair_sequencer;
    import gb80_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op = 2'b00;
    logic [1:0]  i_cmd_pair = 2'b00;
    logic [15:0] i_cmd_data = 16'h0000;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [15:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_rf_wr_en;
    logic        o_rf_rd_en;
    logic [2:0]  o_rf_addr;
    logic [7:0]  o_rf_data;
    logic [7:0]  i_rf_data;
    seq_state_t  o_state;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rf [0:7];
    logic [7:0]  rd_data_q = 8'h00;
    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = 3'd0;
    logic [7:0]  pl_data = 8'h00;
    logic        mon_on = 1'b0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [10:0] exp_q [$];

    assign i_rf_data = rd_data_q;

    always #5 i_clk = ~i_clk;

    reg_pair_sequencer dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_pair  (i_cmd_pair),
        .i_cmd_data  (i_cmd_data),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .o_rf_wr_en  (o_rf_wr_en),
        .o_rf_rd_en  (o_rf_rd_en),
        .o_rf_addr   (o_rf_addr),
        .o_rf_data   (o_rf_data),
        .i_rf_data   (i_rf_data),
        .o_state     (o_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Register-file model: registered read, write on the strobe, plus the write scoreboard.
    always @(posedge i_clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        if (o_rf_rd_en) rd_data_q <= rf[o_rf_addr];
        if (o_rf_wr_en) rf[o_rf_addr] <= o_rf_data;
        if (mon_on) begin
            if (o_rf_rd_en || o_rf_wr_en) begin
                check("strobe_excl", 32'(o_rf_rd_en & o_rf_wr_en), 32'd0);
            end else begin
                check("rf_lines_idle", {21'd0, o_rf_addr, o_rf_data}, 32'd0);
            end
            if (o_rf_rd_en) rd_count <= rd_count + 1;
            if (o_rf_wr_en) begin
                wr_count <= wr_count + 1;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", {21'd0, o_rf_addr, o_rf_data}, 32'h7ff);
                end else begin
                    check("wr_event", {21'd0, o_rf_addr, o_rf_data}, {21'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] addr, input logic [7:0] data);
        pl_en = 1'b1;
        pl_addr = addr;
        pl_data = data;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] data,
                         input string tag);
        check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
        i_cmd_valid = 1'b1;
        i_cmd_op = op;
        i_cmd_pair = pair;
        i_cmd_data = data;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int exp_lat, input string tag);
        int n;
        n = 1;
        while (!o_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic finish_rsp(input logic [15:0] exp_data, input logic exp_err, input string tag);
        check({tag, "_rsp_data"}, 32'(o_rsp_data), 32'(exp_data));
        check({tag, "_rsp_err"}, 32'(o_rsp_err), 32'(exp_err));
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check({tag, "_back_idle"}, {30'd0, o_cmd_ready, o_rsp_valid}, 32'b10);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] data,
                           input int exp_lat, input logic [15:0] exp_data, input logic exp_err,
                           input string tag);
        issue(op, pair, data, tag);
        wait_rsp(exp_lat, tag);
        finish_rsp(exp_data, exp_err, tag);
    endtask

    initial begin
        int rd0, wr0;

        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        mon_on = 1'b1;
        check("reset_outputs",
              {o_cmd_ready, o_rsp_valid, o_rsp_err, o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_data, o_rsp_data},
              {1'b1, 31'd0});
        check("reset_state", 32'(o_state), 32'(IDLE));

        // WRITE BC then READ it back.
        exp_q.push_back({3'd0, 8'h12});
        exp_q.push_back({3'd1, 8'h34});
        run_cmd(OP_WRITE, PAIR_BC, 16'h1234, 3, 16'h1234, 1'b0, "wr_bc");
        check("rf_b", 32'(rf[0]), 32'h12);
        check("rf_c", 32'(rf[1]), 32'h34);
        run_cmd(OP_READ, PAIR_BC, 16'hffff, 4, 16'h1234, 1'b0, "rd_bc");

        // INC HL wraps 0xFFFF to 0x0000 across both bytes.
        preload(3'd4, 8'hff);
        preload(3'd5, 8'hff);
        exp_q.push_back({3'd4, 8'h00});
        exp_q.push_back({3'd5, 8'h00});
        run_cmd(OP_INC, PAIR_HL, 16'h0000, 6, 16'h0000, 1'b0, "inc_hl");

        // DEC DE borrows from the hi byte: 0x0100 -> 0x00FF.
        preload(3'd2, 8'h01);
        preload(3'd3, 8'h00);
        exp_q.push_back({3'd2, 8'h00});
        exp_q.push_back({3'd3, 8'hff});
        run_cmd(OP_DEC, PAIR_DE, 16'h0000, 6, 16'h00ff, 1'b0, "dec_de");

        // Pair 11.
        rd0 = rd_count;
        wr0 = wr_count;
`ifdef REG_PAIR_SEQ_ACCUM_EN
        exp_q.push_back({3'd7, 8'hab});
        run_cmd(OP_WRITE, PAIR_RSVD, 16'h00ab, 2, 16'h00ab, 1'b0, "acc_wr");
        check("acc_wr_count", 32'(wr_count - wr0), 32'd1);
        run_cmd(OP_READ, PAIR_RSVD, 16'h0000, 3, 16'h00ab, 1'b0, "acc_rd");
        exp_q.push_back({3'd7, 8'hac});
        run_cmd(OP_INC, PAIR_RSVD, 16'h0000, 4, 16'h00ac, 1'b0, "acc_inc");
`else
        run_cmd(OP_WRITE, PAIR_RSVD, 16'hbeef, 1, 16'h0000, 1'b1, "rsvd_wr");
        run_cmd(OP_INC, PAIR_RSVD, 16'h0000, 1, 16'h0000, 1'b1, "rsvd_inc");
        check("rsvd_no_strobes", 32'((rd_count - rd0) + (wr_count - wr0)), 32'd0);
`endif

        // Backpressure on a READ of DE; a WRITE offered meanwhile must be ignored.
        issue(OP_READ, PAIR_DE, 16'h0000, "bp");
        wait_rsp(4, "bp");
        wr0 = wr_count;
        for (int i = 0; i < 5; i++) begin
            i_cmd_valid = 1'b1;
            i_cmd_op = OP_WRITE;
            i_cmd_pair = PAIR_DE;
            i_cmd_data = 16'hbeef;
            check("bp_hold", {o_rsp_valid, o_cmd_ready, o_rsp_err, 13'd0, o_rsp_data}, {3'b100, 13'd0, 16'h00ff});
            tick();
        end
        i_cmd_valid = 1'b0;
        check("bp_no_write", 32'(wr_count - wr0), 32'd0);
        finish_rsp(16'h00ff, 1'b0, "bp");
        run_cmd(OP_READ, PAIR_DE, 16'h0000, 4, 16'h00ff, 1'b0, "de_unchanged");

        // Reset while INC BC is in WR_H: only the hi byte lands.
        issue(OP_INC, PAIR_BC, 16'h0000, "rst_inc");
        tick();
        tick();
        tick();
        check("rst_in_wr_h", 32'(o_state), 32'(WR_H));
        check("rst_wr_h_lines", {21'd0, o_rf_wr_en, o_rf_addr, o_rf_data}, {21'd0, 1'b1, 3'd0, 8'h12});
        exp_q.push_back({3'd0, 8'h12});
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("rst_state", 32'(o_state), 32'(IDLE));
        check("rst_outputs",
              {o_cmd_ready, o_rsp_valid, o_rsp_err, o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_data, o_rsp_data},
              {1'b1, 31'd0});
        tick();
        check("rst_quiet", {30'd0, o_rf_wr_en, o_rf_rd_en}, 32'd0);
        run_cmd(OP_READ, PAIR_BC, 16'h0000, 4, 16'h1234, 1'b0, "rst_rd_bc");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
